mario_life_ctrl: RTL and testbench
==================================

MARIO_LIFE_CTRL -- requirements
Module: mario_life_ctrl

Interface
REQ-001 Parameter DEATH_FRAMES, default 60: frames the Mario death animation lasts (1..255).
REQ-002 Parameter SQUASH_FRAMES, default 30: frames the squashed Goomba stays visible (1..255).
REQ-003 Parameter START_LIVES, default 3: lives loaded at game start (1..3).
REQ-004 Parameter STOMP_POINTS, default 100: score added per stomp.
REQ-005 Clk  in  1  system clock, 50 MHz; all logic on its rising edge.
REQ-006 Reset  in  1  synchronous, active-low reset, sampled on Clk rising edge.
REQ-007 frame_tick  in  1  one-Clk pulse per video frame.
REQ-008 start  in  1  one-Clk start/restart pulse from the keyboard decoder.
REQ-009 is_Mario_die  in  1  sticky collision verdict: Mario killed.
REQ-010 is_goomba_die  in  1  sticky collision verdict: Goomba stomped.
REQ-011 collide_rst  out  1  one-Clk active-high pulse that clears the collision verdict stage.
REQ-012 mario_respawn  out  1  one-Clk pulse telling the Mario motion block to reload its start position.
REQ-013 mario_dying  out  1  high while the death animation plays.
REQ-014 goomba_squashed  out  1  high while the squash sprite is shown.
REQ-015 goomba_gone  out  1  high once the squash period ends; Goomba is not drawn.
REQ-016 lives  out  2  remaining lives.
REQ-017 score  out  16  unsigned score.
REQ-018 game_over  out  1  high in GAME_OVER.
REQ-019 playing  out  1  high in PLAY.

Function
REQ-020 The FSM SHALL have the states IDLE, PLAY, DYING, RESPAWN and GAME_OVER.
REQ-021 IDLE: on start, the block SHALL load lives=START_LIVES, clear score, pulse collide_rst and mario_respawn, then enter PLAY on the next cycle.
REQ-022 PLAY: when is_Mario_die=1, the block SHALL enter DYING, clear the frame counter and raise mario_dying on the next cycle.
REQ-023 PLAY: when is_goomba_die=1, squash is not active and the stomp_scored flag is clear, the block SHALL add STOMP_POINTS to score, set stomp_scored, set goomba_squashed and clear the squash counter.
REQ-024 Score addition SHALL saturate at 16'hFFFF and never wrap.
REQ-025 If is_Mario_die and is_goomba_die are both 1 in the same PLAY cycle, the death path SHALL win and no score SHALL be added.
REQ-026 The squash counter SHALL increment only on frame_tick while goomba_squashed=1, in any state other than IDLE and GAME_OVER.
REQ-027 On the frame_tick on which the squash counter equals SQUASH_FRAMES-1, goomba_squashed SHALL clear and goomba_gone SHALL set on the next cycle.
REQ-028 DYING: the frame counter SHALL increment on each frame_tick.
REQ-029 DYING: on the frame_tick on which the frame counter equals DEATH_FRAMES-1, and lives>1, the block SHALL decrement lives and enter RESPAWN.
REQ-030 DYING: under the same condition with lives==1, the block SHALL set lives=0 and enter GAME_OVER.
REQ-031 RESPAWN SHALL last exactly one cycle, SHALL pulse collide_rst and mario_respawn, SHALL clear mario_dying, goomba_squashed, goomba_gone and stomp_scored, and SHALL then enter PLAY.
REQ-032 GAME_OVER: score and lives SHALL hold; on start, the block SHALL behave exactly as IDLE+start (REQ-021).
REQ-033 start SHALL be ignored in PLAY, DYING and RESPAWN.
REQ-034 is_Mario_die and is_goomba_die SHALL be ignored outside PLAY, except that an active squash keeps counting per REQ-026.
REQ-035 frame_tick and start in the same cycle SHALL not interact; both SHALL be handled.
REQ-036 collide_rst and mario_respawn SHALL be registered outputs, high for exactly one Clk per event.
REQ-037 Latency from the qualifying input edge to the state or output change SHALL be one Clk.

Reset
REQ-038 With Reset=0 at a Clk edge, the block SHALL go to IDLE.
REQ-039 Reset values SHALL be: lives=0, score=0, all flags and counters 0, collide_rst=0, mario_respawn=0, playing=0, game_over=0.
REQ-040 Reset asserted mid-DYING or mid-squash SHALL abort the operation with no lives or score update.

Verification
REQ-041 Reset low 2 cycles, then start -> lives=3, score=0, one collide_rst pulse, playing=1 one cycle later.
REQ-042 PLAY, is_goomba_die held high for 100 frames -> score=100 exactly once; goomba_squashed for 30 frame_ticks, then goomba_gone=1.
REQ-043 PLAY, lives=3, is_Mario_die=1 -> mario_dying for 60 frame_ticks; lives=2; one collide_rst pulse and one mario_respawn pulse; PLAY resumes.
REQ-044 Three deaths from START_LIVES=3 -> lives=0, game_over=1; a further start -> lives=3, score=0, PLAY.
REQ-045 score=16'hFFC0 plus a stomp -> score=16'hFFFF; both verdicts high in the same cycle -> DYING, score unchanged.
REQ-046 Reset driven low at frame 20 of DYING -> IDLE next cycle, all outputs at their reset values.

Source files
------------

// File: rtl/mario_life_ctrl_if.sv
// Signal bundle between the Mario life/score controller and the game logic around it.
// The controller takes the slave view; the frame timing, keyboard and collision side is the master.
interface mario_life_ctrl_if;
    logic        frame_tick;
    logic        start;
    logic        is_Mario_die;
    logic        is_goomba_die;
    logic        collide_rst;
    logic        mario_respawn;
    logic        mario_dying;
    logic        goomba_squashed;
    logic        goomba_gone;
    logic [1:0]  lives;
    logic [15:0] score;
    logic        game_over;
    logic        playing;

    modport master (
        output frame_tick,
        output start,
        output is_Mario_die,
        output is_goomba_die,
        input  collide_rst,
        input  mario_respawn,
        input  mario_dying,
        input  goomba_squashed,
        input  goomba_gone,
        input  lives,
        input  score,
        input  game_over,
        input  playing
    );

    modport slave (
        input  frame_tick,
        input  start,
        input  is_Mario_die,
        input  is_goomba_die,
        output collide_rst,
        output mario_respawn,
        output mario_dying,
        output goomba_squashed,
        output goomba_gone,
        output lives,
        output score,
        output game_over,
        output playing
    );
endinterface

// File: rtl/mario_life_ctrl.sv
// Mario life/score controller: game state, lives, saturating score, death animation timing and
// goomba squash timing. Everything is on the rising Clk edge with a synchronous active-low Reset.
module mario_life_ctrl #(
    parameter int unsigned DEATH_FRAMES  = 60,
    parameter int unsigned SQUASH_FRAMES = 30,
    parameter int unsigned START_LIVES   = 3,
    parameter int unsigned STOMP_POINTS  = 100
) (
    input logic              Clk,
    input logic              Reset,
    mario_life_ctrl_if.slave bus
);

    localparam logic [7:0] DeathLast  = 8'(DEATH_FRAMES - 1);
    localparam logic [7:0] SquashLast = 8'(SQUASH_FRAMES - 1);
    localparam logic [1:0] StartLives = 2'(START_LIVES);

    typedef enum logic [2:0] {
        StIdle,
        StPlay,
        StDying,
        StRespawn,
        StGameOver
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  lives_q, lives_d;
    logic [15:0] score_q, score_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]  squash_cnt_q, squash_cnt_d;
    logic        squashed_q, squashed_d;
    logic        gone_q, gone_d;
    logic        stomp_scored_q, stomp_scored_d;
    logic        collide_rst_q, collide_rst_d;
    logic        respawn_q, respawn_d;
    logic [31:0] score_sum;
    logic        squash_run;

    assign score_sum  = {16'd0, score_q} + STOMP_POINTS;
    // The squash sprite keeps timing out even while Mario is dying or respawning.
    assign squash_run = squashed_q && bus.frame_tick &&
                        (state_q != StIdle) && (state_q != StGameOver);

    always_comb begin
        state_d        = state_q;
        lives_d        = lives_q;
        score_d        = score_q;
        frame_cnt_d    = frame_cnt_q;
        squash_cnt_d   = squash_cnt_q;
        squashed_d     = squashed_q;
        gone_d         = gone_q;
        stomp_scored_d = stomp_scored_q;
        collide_rst_d  = 1'b0;
        respawn_d      = 1'b0;

        if (squash_run) begin
            if (squash_cnt_q == SquashLast) begin
                squashed_d = 1'b0;
                gone_d     = 1'b1;
            end else begin
                squash_cnt_d = squash_cnt_q + 8'd1;
            end
        end

        case (state_q)
            StIdle, StGameOver: begin
                if (bus.start) begin
                    state_d        = StPlay;
                    lives_d        = StartLives;
                    score_d        = 16'd0;
                    frame_cnt_d    = 8'd0;
                    squash_cnt_d   = 8'd0;
                    squashed_d     = 1'b0;
                    gone_d         = 1'b0;
                    stomp_scored_d = 1'b0;
                    collide_rst_d  = 1'b1;
                    respawn_d      = 1'b1;
                end
            end
            StPlay: begin
                // A simultaneous kill and stomp resolves as a kill.
                if (bus.is_Mario_die) begin
                    state_d     = StDying;
                    frame_cnt_d = 8'd0;
                end else if (bus.is_goomba_die && !squashed_q && !stomp_scored_q) begin
                    score_d        = (score_sum > 32'h0000_FFFF) ? 16'hFFFF : score_sum[15:0];
                    stomp_scored_d = 1'b1;
                    squashed_d     = 1'b1;
                    squash_cnt_d   = 8'd0;
                end
            end
            StDying: begin
                if (bus.frame_tick) begin
                    if (frame_cnt_q == DeathLast) begin
                        if (lives_q > 2'd1) begin
                            lives_d = lives_q - 2'd1;
                            state_d = StRespawn;
                        end else begin
                            lives_d = 2'd0;
                            state_d = StGameOver;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            StRespawn: begin
                state_d        = StPlay;
                squash_cnt_d   = 8'd0;
                squashed_d     = 1'b0;
                gone_d         = 1'b0;
                stomp_scored_d = 1'b0;
                collide_rst_d  = 1'b1;
                respawn_d      = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q        <= StIdle;
            lives_q        <= 2'd0;
            score_q        <= 16'd0;
            frame_cnt_q    <= 8'd0;
            squash_cnt_q   <= 8'd0;
            squashed_q     <= 1'b0;
            gone_q         <= 1'b0;
            stomp_scored_q <= 1'b0;
            collide_rst_q  <= 1'b0;
            respawn_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            lives_q        <= lives_d;
            score_q        <= score_d;
            frame_cnt_q    <= frame_cnt_d;
            squash_cnt_q   <= squash_cnt_d;
            squashed_q     <= squashed_d;
            gone_q         <= gone_d;
            stomp_scored_q <= stomp_scored_d;
            collide_rst_q  <= collide_rst_d;
            respawn_q      <= respawn_d;
        end
    end

    assign bus.collide_rst     = collide_rst_q;
    assign bus.mario_respawn   = respawn_q;
    assign bus.mario_dying     = (state_q == StDying);
    assign bus.goomba_squashed = squashed_q;
    assign bus.goomba_gone     = gone_q;
    assign bus.lives           = lives_q;
    assign bus.score           = score_q;
    assign bus.game_over       = (state_q == StGameOver);
    assign bus.playing         = (state_q == StPlay);

endmodule

// File: tb/tb_mario_life_ctrl.sv
// Bench for mario_life_ctrl: directed table and sequences on a default-parameter instance, plus
// random stimulus on a short-timer instance checked against a countdown-based reference model.
module tb_mario_life_ctrl;

    // Second instance: short timers and a large stomp value so saturation is reachable.
    localparam int BD = 3;
    localparam int BS = 2;
    localparam int BL = 3;
    localparam int BP = 32752;

    localparam int MIdle = 0, MPlay = 1, MDying = 2, MResp = 3, MOver = 4;

    logic Clk = 1'b0;
    logic ResetA = 1'b0;
    logic ResetB = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int coll_cnt = 0;
    int resp_cnt = 0;

    mario_life_ctrl_if ifa ();
    mario_life_ctrl_if ifb ();

    mario_life_ctrl dut_a (
        .Clk   (Clk),
        .Reset (ResetA),
        .bus   (ifa)
    );

    mario_life_ctrl #(
        .DEATH_FRAMES  (BD),
        .SQUASH_FRAMES (BS),
        .START_LIVES   (BL),
        .STOMP_POINTS  (BP)
    ) dut_b (
        .Clk   (Clk),
        .Reset (ResetB),
        .bus   (ifb)
    );

    always #10 Clk = ~Clk;

    typedef struct {
        bit rst, ft, st, md, gd;
        int lives, score;
        bit playing, over, dying, coll, resp, sq;
    } vec_t;

    vec_t tbl[12];

    // reference model state (B instance)
    int m_mode, m_lives, m_score, m_death_left, m_squash_left;
    bit m_gone, m_scored, m_pulse;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input bit rst, input bit ft, input bit st, input bit md, input bit gd);
        ResetA = rst;
        ifa.frame_tick = ft;
        ifa.start = st;
        ifa.is_Mario_die = md;
        ifa.is_goomba_die = gd;
        @(posedge Clk);
        #1;
        ResetA = 1'b1;
        ifa.frame_tick = 1'b0;
        ifa.start = 1'b0;
        ifa.is_Mario_die = 1'b0;
        ifa.is_goomba_die = 1'b0;
        if (ifa.collide_rst) coll_cnt++;
        if (ifa.mario_respawn) resp_cnt++;
    endtask

    // Ticks frames until the death animation ends; leaves the DUT one cycle past it.
    task automatic run_death(output int ticks);
        ticks = 0;
        while (ifa.mario_dying && ticks < 200) begin
            cyc(1, 1, 0, 0, 0);
            ticks++;
            cyc(1, 0, 0, 0, 0);
        end
    endtask

    task automatic model_step(input bit rst, input bit ft, input bit st, input bit md,
                              input bit gd);
        int old_sq;
        old_sq = m_squash_left;
        m_pulse = 0;
        if (!rst) begin
            m_mode = MIdle; m_lives = 0; m_score = 0; m_death_left = 0;
            m_squash_left = 0; m_gone = 0; m_scored = 0;
            return;
        end
        if (old_sq > 0 && ft && m_mode != MIdle && m_mode != MOver) begin
            m_squash_left--;
            if (m_squash_left == 0) m_gone = 1;
        end
        case (m_mode)
            MIdle, MOver: if (st) begin
                m_mode = MPlay; m_lives = BL; m_score = 0; m_pulse = 1;
                m_squash_left = 0; m_gone = 0; m_scored = 0;
            end
            MPlay: begin
                if (md) begin
                    m_mode = MDying;
                    m_death_left = BD;
                end else if (gd && old_sq == 0 && !m_scored) begin
                    m_score = (m_score + BP > 65535) ? 65535 : m_score + BP;
                    m_scored = 1;
                    m_squash_left = BS;
                end
            end
            MDying: if (ft) begin
                m_death_left--;
                if (m_death_left == 0) begin
                    if (m_lives > 1) begin
                        m_lives--;
                        m_mode = MResp;
                    end else begin
                        m_lives = 0;
                        m_mode = MOver;
                    end
                end
            end
            default: begin
                m_mode = MPlay; m_pulse = 1;
                m_squash_left = 0; m_gone = 0; m_scored = 0;
            end
        endcase
    endtask

    task automatic step_b(input bit rst, input bit ft, input bit st, input bit md, input bit gd);
        ResetB = rst;
        ifb.frame_tick = ft;
        ifb.start = st;
        ifb.is_Mario_die = md;
        ifb.is_goomba_die = gd;
        @(posedge Clk);
        #1;
        model_step(rst, ft, st, md, gd);
        chk("b_lives", ifb.lives, m_lives);
        chk("b_score", ifb.score, m_score);
        chk("b_playing", ifb.playing, m_mode == MPlay);
        chk("b_game_over", ifb.game_over, m_mode == MOver);
        chk("b_dying", ifb.mario_dying, m_mode == MDying);
        chk("b_squashed", ifb.goomba_squashed, m_squash_left > 0);
        chk("b_gone", ifb.goomba_gone, m_gone);
        chk("b_collide_rst", ifb.collide_rst, m_pulse);
        chk("b_respawn", ifb.mario_respawn, m_pulse);
    endtask

    task automatic b_life();
        int guard;
        step_b(1, 0, 0, 1, 0);
        guard = 0;
        while (ifb.mario_dying && guard < 20) begin
            step_b(1, 1, 0, 0, 0);
            guard++;
        end
        step_b(1, 0, 0, 0, 0);
    endtask

    initial begin
        int t;
        int first_clear;

        ifa.frame_tick = 0; ifa.start = 0; ifa.is_Mario_die = 0; ifa.is_goomba_die = 0;
        ifb.frame_tick = 0; ifb.start = 0; ifb.is_Mario_die = 0; ifb.is_goomba_die = 0;

        //          rst ft st md gd lives score ply ovr dyg col rsp sq
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0};
        tbl[3]  = '{1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, 0, 1, 0, 0, 3, 0,   1, 0, 0, 1, 1, 0};
        tbl[5]  = '{1, 0, 0, 0, 0, 3, 0,   1, 0, 0, 0, 0, 0};
        tbl[6]  = '{1, 0, 1, 0, 0, 3, 0,   1, 0, 0, 0, 0, 0};
        tbl[7]  = '{1, 0, 0, 0, 1, 3, 100, 1, 0, 0, 0, 0, 1};
        tbl[8]  = '{1, 1, 0, 0, 1, 3, 100, 1, 0, 0, 0, 0, 1};
        tbl[9]  = '{1, 0, 0, 1, 0, 3, 100, 0, 0, 1, 0, 0, 1};
        tbl[10] = '{1, 0, 1, 0, 0, 3, 100, 0, 0, 1, 0, 0, 1};
        tbl[11] = '{1, 1, 0, 0, 1, 3, 100, 0, 0, 1, 0, 0, 1};

        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].rst, tbl[i].ft, tbl[i].st, tbl[i].md, tbl[i].gd);
            chk($sformatf("v%0d_lives", i), ifa.lives, tbl[i].lives);
            chk($sformatf("v%0d_score", i), ifa.score, tbl[i].score);
            chk($sformatf("v%0d_playing", i), ifa.playing, tbl[i].playing);
            chk($sformatf("v%0d_game_over", i), ifa.game_over, tbl[i].over);
            chk($sformatf("v%0d_dying", i), ifa.mario_dying, tbl[i].dying);
            chk($sformatf("v%0d_collide_rst", i), ifa.collide_rst, tbl[i].coll);
            chk($sformatf("v%0d_respawn", i), ifa.mario_respawn, tbl[i].resp);
            chk($sformatf("v%0d_squashed", i), ifa.goomba_squashed, tbl[i].sq);
        end

        // Stomp held for 100 frames: scored once, squash lasts 30 ticks.
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 1);
        chk("stomp_score", ifa.score, 100);
        chk("stomp_squashed", ifa.goomba_squashed, 1);
        first_clear = -1;
        for (int f = 1; f <= 100; f++) begin
            cyc(1, 1, 0, 0, 1);
            if (first_clear < 0 && !ifa.goomba_squashed) first_clear = f;
            cyc(1, 0, 0, 0, 1);
        end
        chk("squash_ticks", first_clear, 30);
        chk("goomba_gone", ifa.goomba_gone, 1);
        chk("score_once", ifa.score, 100);

        // One death with lives to spare.
        coll_cnt = 0;
        resp_cnt = 0;
        cyc(1, 0, 0, 1, 0);
        chk("die_dying", ifa.mario_dying, 1);
        run_death(t);
        chk("death_ticks", t, 60);
        chk("death_lives", ifa.lives, 2);
        chk("death_playing", ifa.playing, 1);
        chk("respawn_gone_clr", ifa.goomba_gone, 0);
        repeat (3) cyc(1, 0, 0, 0, 0);
        chk("collide_pulses", coll_cnt, 1);
        chk("respawn_pulses", resp_cnt, 1);
        cyc(1, 0, 0, 0, 1);
        chk("second_life_stomp", ifa.score, 200);

        // Two more deaths end the game; score held.
        cyc(1, 0, 0, 1, 0);
        run_death(t);
        chk("death2_ticks", t, 60);
        chk("death2_lives", ifa.lives, 1);
        cyc(1, 0, 0, 1, 0);
        run_death(t);
        chk("death3_ticks", t, 60);
        chk("over_lives", ifa.lives, 0);
        chk("over_flag", ifa.game_over, 1);
        chk("over_playing", ifa.playing, 0);
        chk("over_score", ifa.score, 200);
        cyc(1, 1, 0, 1, 1);
        chk("over_ignore_verdict", ifa.score, 200);
        cyc(1, 1, 1, 0, 0);
        chk("restart_lives", ifa.lives, 3);
        chk("restart_score", ifa.score, 0);
        chk("restart_playing", ifa.playing, 1);
        chk("restart_collide", ifa.collide_rst, 1);

        // Kill and stomp together: kill wins, no points.
        cyc(1, 0, 0, 1, 1);
        chk("both_dying", ifa.mario_dying, 1);
        chk("both_score", ifa.score, 0);

        // Reset at frame 20 of the death animation.
        repeat (20) cyc(1, 1, 0, 0, 0);
        chk("mid_still_dying", ifa.mario_dying, 1);
        cyc(0, 0, 0, 0, 0);
        chk("rst_lives", ifa.lives, 0);
        chk("rst_score", ifa.score, 0);
        chk("rst_dying", ifa.mario_dying, 0);
        chk("rst_playing", ifa.playing, 0);
        chk("rst_game_over", ifa.game_over, 0);
        chk("rst_collide", ifa.collide_rst, 0);
        chk("rst_respawn", ifa.mario_respawn, 0);
        chk("rst_squashed", ifa.goomba_squashed, 0);
        chk("rst_gone", ifa.goomba_gone, 0);

        // Saturation on the short-timer instance: 0x7FF0, 0xFFE0, then clipped.
        step_b(0, 0, 0, 0, 0);
        step_b(0, 0, 0, 0, 0);
        step_b(1, 0, 1, 0, 0);
        step_b(1, 0, 0, 0, 1);
        chk("sat_first", ifb.score, 16'h7FF0);
        b_life();
        step_b(1, 0, 0, 0, 1);
        chk("sat_second", ifb.score, 16'hFFE0);
        b_life();
        step_b(1, 0, 0, 0, 1);
        chk("sat_clip", ifb.score, 16'hFFFF);

        // Random stress against the reference model.
        for (int c = 0; c < 3000; c++) begin
            step_b($urandom_range(0, 199) != 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0,
                   $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
